id_ex_reg: RTL and testbench
============================

# id_ex_reg

ID/EX pipeline stage register for the five-stage MIPS datapath. It sits directly downstream of the control unit and register file. It captures the decoded control bundles (WB, M, EX), the operand data, the immediate and the register specifiers each cycle. It also owns load-use hazard detection: it inserts a one-cycle bubble and tells the fetch/decode stages to hold.

## Interface
Parameters:
- DW, 32, datapath width (operands, immediate, PC+4)
- CW, 16, width of the bubble performance counter

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous reset, active-low
- id_wb  in  2  WB bundle from control unit, {MtoR, Urw}
- id_m  in  3  M bundle, {Branch, MRead, MWrite}
- id_ex  in  5  EX bundle, {RegDs, AOp[2:0], ALUsrc}
- id_pc4, id_rd1, id_rd2, id_imm  in  DW each  PC+4, register-file read data 1/2, sign-extended immediate
- id_rs, id_rt, id_rd  in  5 each  register specifiers of the instruction in ID
- id_uses_rt  in  1  instruction in ID reads rt as a source (R-type, store, beq)
- flush_i  in  1  branch taken; squash the instruction entering EX
- stall_i  in  1  global hold (e.g. memory wait); freeze this stage
- ex_wb, ex_m, ex_ex  out  2/3/5  registered control bundles
- ex_pc4, ex_rd1, ex_rd2, ex_imm  out  DW each  registered data
- ex_rs, ex_rt, ex_rd  out  5 each  registered specifiers
- ex_valid  out  1  EX holds a real instruction (0 = bubble)
- stall_o  out  1  load-use hazard; PC and IF/ID must hold this cycle
- bubble_cnt  out  CW  count of hazard bubbles inserted, saturating

## Operation
- Hazard (combinational, from current EX registers and ID inputs): hzd = ex_valid & ex_m[1] (MRead) & (ex_rt != 0) & ((ex_rt == id_rs) | (id_uses_rt & ex_rt == id_rt)). stall_o = hzd.
- Update priority at each rising edge, highest first:
  1. !rst_n: every output register is cleared to 0, including ex_valid and bubble_cnt.
  2. flush_i: bubble. ex_wb, ex_m and ex_ex are set to 0 and ex_valid to 0. Data and specifier fields load from ID (don't-care).
  3. stall_i: all registers hold, including bubble_cnt.
  4. hzd: bubble as in step 2, and bubble_cnt increments.
  5. Otherwise: load all ID inputs and set ex_valid to 1.
- A bubble must carry zero control: Urw=0, MWrite=0, MRead=0, Branch=0. This guarantees no architectural side effect downstream.
- flush_i together with hzd: flush wins and bubble_cnt does not increment. stall_o still reflects hzd combinationally.
- stall_i together with hzd: hold. No bubble is inserted and the count is not taken.
- bubble_cnt saturates at 2^CW−1 and never wraps.
- A hazard lasts at most one cycle. After the bubble, ex_m[1]=0, so hzd drops and the held instruction then loads normally.
- The $zero destination (ex_rt=0) never raises a hazard.

## Timing
- Latency: ID inputs appear on ex_* one clock after the edge that captures them.
- stall_o is combinational from registered state and current ID inputs. It is valid within the same cycle and has no register delay.
- Reset is synchronous only. Asserting rst_n=0 mid-hazard clears everything on the next edge, and stall_o falls once the EX registers are cleared.
- All outputs are 0 out of reset. The first instruction after release of rst_n appears one edge later with ex_valid=1.

## Test plan
- Reset: hold rst_n=0 for 2 cycles with nonzero inputs -> all outputs 0 and bubble_cnt=0. Release rst_n, present R-type (wb=2'b11, m=3'b000, ex=5'b10100, rd1=32'h5, rd2=32'h7) -> next edge ex_* match and ex_valid=1.
- Load-use: lw with rt=8 (m=3'b010) loaded. Next ID instruction has id_rs=8 -> stall_o=1 that cycle, next edge ex_m=0, ex_valid=0, bubble_cnt=1. Following edge the add loads and stall_o=0.
- No false hazard: lw rt=0 followed by id_rs=0 -> stall_o=0. lw rt=9 followed by id_rt=9 with id_uses_rt=0 -> stall_o=0.
- Flush priority: hazard condition present and flush_i=1 -> bubble inserted, bubble_cnt unchanged.
- Stall hold: load values, then stall_i=1 for 3 cycles with changing ID inputs -> ex_* and bubble_cnt frozen. Release -> the current ID instruction loads.
- Saturation (CW=2): force 5 hazard bubbles -> bubble_cnt stops at 3.

Source files
------------

// File: rtl/id_ex_reg.sv
// ID/EX pipeline register for the five-stage MIPS datapath.
// Also owns load-use hazard detection, bubble insertion and a saturating bubble counter.
module id_ex_reg #(
    parameter int DW = 32,
    parameter int CW = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [1:0]    id_wb,
    input  logic [2:0]    id_m,
    input  logic [4:0]    id_ex,
    input  logic [DW-1:0] id_pc4,
    input  logic [DW-1:0] id_rd1,
    input  logic [DW-1:0] id_rd2,
    input  logic [DW-1:0] id_imm,
    input  logic [4:0]    id_rs,
    input  logic [4:0]    id_rt,
    input  logic [4:0]    id_rd,
    input  logic          id_uses_rt,
    input  logic          flush_i,
    input  logic          stall_i,
    output logic [1:0]    ex_wb,
    output logic [2:0]    ex_m,
    output logic [4:0]    ex_ex,
    output logic [DW-1:0] ex_pc4,
    output logic [DW-1:0] ex_rd1,
    output logic [DW-1:0] ex_rd2,
    output logic [DW-1:0] ex_imm,
    output logic [4:0]    ex_rs,
    output logic [4:0]    ex_rt,
    output logic [4:0]    ex_rd,
    output logic          ex_valid,
    output logic          stall_o,
    output logic [CW-1:0] bubble_cnt
);

    localparam logic [CW-1:0] CNT_MAX = '1;

    logic hzd;
    logic rt_match;
    logic take_bubble;

    // A load in EX whose nonzero destination is read by the instruction in ID.
    assign rt_match    = id_uses_rt && (ex_rt == id_rt);
    assign hzd         = ex_valid && ex_m[1] && (ex_rt != 5'd0) && ((ex_rt == id_rs) || rt_match);
    assign stall_o     = hzd;
    assign take_bubble = flush_i || hzd;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ex_wb    <= '0;
            ex_m     <= '0;
            ex_ex    <= '0;
            ex_valid <= 1'b0;
        end else if (flush_i || !stall_i) begin
            // Bubbles carry zero control so nothing downstream can write state.
            if (take_bubble) begin
                ex_wb    <= '0;
                ex_m     <= '0;
                ex_ex    <= '0;
                ex_valid <= 1'b0;
            end else begin
                ex_wb    <= id_wb;
                ex_m     <= id_m;
                ex_ex    <= id_ex;
                ex_valid <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ex_pc4 <= '0;
            ex_rd1 <= '0;
            ex_rd2 <= '0;
            ex_imm <= '0;
            ex_rs  <= '0;
            ex_rt  <= '0;
            ex_rd  <= '0;
        end else if (flush_i || !stall_i) begin
            ex_pc4 <= id_pc4;
            ex_rd1 <= id_rd1;
            ex_rd2 <= id_rd2;
            ex_imm <= id_imm;
            ex_rs  <= id_rs;
            ex_rt  <= id_rt;
            ex_rd  <= id_rd;
        end
    end

    // Only hazard bubbles count; flushes win over a hazard and stalls suppress it.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bubble_cnt <= '0;
        end else if (!flush_i && !stall_i && hzd && (bubble_cnt != CNT_MAX)) begin
            bubble_cnt <= bubble_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_id_ex_reg.sv
// Self-checking bench for id_ex_reg: a behavioural model checked every cycle,
// plus directed vectors with hand-computed literal expectations.
module tb_id_ex_reg;

    localparam int DW = 32;
    localparam int CW = 2;

    logic          clk;
    logic          rst_n;
    logic [1:0]    id_wb;
    logic [2:0]    id_m;
    logic [4:0]    id_ex;
    logic [DW-1:0] id_pc4, id_rd1, id_rd2, id_imm;
    logic [4:0]    id_rs, id_rt, id_rd;
    logic          id_uses_rt;
    logic          flush_i, stall_i;
    logic [1:0]    ex_wb;
    logic [2:0]    ex_m;
    logic [4:0]    ex_ex;
    logic [DW-1:0] ex_pc4, ex_rd1, ex_rd2, ex_imm;
    logic [4:0]    ex_rs, ex_rt, ex_rd;
    logic          ex_valid, stall_o;
    logic [CW-1:0] bubble_cnt;

    int errors = 0;
    int checks = 0;

    id_ex_reg #(.DW(DW), .CW(CW)) dut (
        .clk(clk), .rst_n(rst_n),
        .id_wb(id_wb), .id_m(id_m), .id_ex(id_ex),
        .id_pc4(id_pc4), .id_rd1(id_rd1), .id_rd2(id_rd2), .id_imm(id_imm),
        .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .id_uses_rt(id_uses_rt),
        .flush_i(flush_i), .stall_i(stall_i),
        .ex_wb(ex_wb), .ex_m(ex_m), .ex_ex(ex_ex),
        .ex_pc4(ex_pc4), .ex_rd1(ex_rd1), .ex_rd2(ex_rd2), .ex_imm(ex_imm),
        .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rd(ex_rd),
        .ex_valid(ex_valid), .stall_o(stall_o), .bubble_cnt(bubble_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Model: what EX should hold, described as "the last instruction admitted".
    typedef struct {
        bit          live;
        bit          valid;
        bit [1:0]    wb;
        bit [2:0]    m;
        bit [4:0]    ex;
        bit [DW-1:0] pc4, rd1, rd2, imm;
        bit [4:0]    rs, rt, rd;
        int          bubbles;
    } model_t;

    model_t mdl = '{default: 0};

    // True when EX holds a real load whose nonzero target the ID instruction reads.
    function automatic bit modelHazard();
        bit reads_target;
        reads_target = (id_rs == mdl.rt) || (id_uses_rt && id_rt == mdl.rt);
        return mdl.valid && (mdl.m == 3'b010 || mdl.m[1]) && mdl.rt != 0 && reads_target;
    endfunction

    always @(posedge clk) begin
        bit hz;
        hz = modelHazard();
        mdl.live = 1'b1;
        if (!rst_n) begin
            mdl = '{default: 0};
            mdl.live = 1'b1;
        end else if (flush_i || (!stall_i && hz)) begin
            mdl.valid = 1'b0;
            mdl.wb = 0; mdl.m = 0; mdl.ex = 0;
            if (!flush_i) mdl.bubbles = (mdl.bubbles + 1 > 3) ? 3 : mdl.bubbles + 1;
        end else if (!stall_i) begin
            mdl.valid = 1'b1;
            mdl.wb = id_wb; mdl.m = id_m; mdl.ex = id_ex;
            mdl.pc4 = id_pc4; mdl.rd1 = id_rd1; mdl.rd2 = id_rd2; mdl.imm = id_imm;
            mdl.rs = id_rs; mdl.rt = id_rt; mdl.rd = id_rd;
        end
    end

    always @(negedge clk) begin
        if (mdl.live) begin
            checkOutput("ex_valid", 64'(ex_valid), 64'(mdl.valid));
            checkOutput("ex_wb", 64'(ex_wb), 64'(mdl.wb));
            checkOutput("ex_m", 64'(ex_m), 64'(mdl.m));
            checkOutput("ex_ex", 64'(ex_ex), 64'(mdl.ex));
            checkOutput("bubble_cnt", 64'(bubble_cnt), 64'(mdl.bubbles));
            checkOutput("stall_o", 64'(stall_o), 64'(modelHazard()));
            if (mdl.valid) begin
                checkOutput("ex_pc4", 64'(ex_pc4), 64'(mdl.pc4));
                checkOutput("ex_rd1", 64'(ex_rd1), 64'(mdl.rd1));
                checkOutput("ex_rd2", 64'(ex_rd2), 64'(mdl.rd2));
                checkOutput("ex_imm", 64'(ex_imm), 64'(mdl.imm));
                checkOutput("ex_rs", 64'(ex_rs), 64'(mdl.rs));
                checkOutput("ex_rt", 64'(ex_rt), 64'(mdl.rt));
                checkOutput("ex_rd", 64'(ex_rd), 64'(mdl.rd));
            end
        end
    end

    task automatic applyStimulus(input logic [1:0] wb, input logic [2:0] m, input logic [4:0] ex,
                                 input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                                 input logic ut, input logic [DW-1:0] rd1, input logic [DW-1:0] rd2);
        id_wb = wb; id_m = m; id_ex = ex;
        id_rs = rs; id_rt = rt; id_rd = rd; id_uses_rt = ut;
        id_rd1 = rd1; id_rd2 = rd2;
        id_pc4 = 32'h400 + {rd1[7:0], 2'b00};
        id_imm = rd2 ^ 32'hFFFF_0000;
        #1;
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    initial begin
        rst_n = 1'b0; flush_i = 1'b0; stall_i = 1'b0;
        applyStimulus(2'b11, 3'b111, 5'b11111, 5'd3, 5'd4, 5'd5, 1'b1, 32'hDEAD, 32'hBEEF);
        step(); step();
        checkOutput("reset_valid", 64'(ex_valid), 64'd0);
        checkOutput("reset_cnt", 64'(bubble_cnt), 64'd0);
        checkOutput("reset_rd1", 64'(ex_rd1), 64'd0);

        // R-type after reset release
        rst_n = 1'b1;
        applyStimulus(2'b11, 3'b000, 5'b10100, 5'd1, 5'd2, 5'd3, 1'b1, 32'h5, 32'h7);
        step();
        checkOutput("rtype_valid", 64'(ex_valid), 64'd1);
        checkOutput("rtype_rd1", 64'(ex_rd1), 64'h5);
        checkOutput("rtype_rd2", 64'(ex_rd2), 64'h7);
        checkOutput("rtype_ex", 64'(ex_ex), 64'b10100);

        // Load-use: lw rt=8 then add reading rs=8
        applyStimulus(2'b11, 3'b010, 5'b00001, 5'd1, 5'd8, 5'd0, 1'b0, 32'h10, 32'h0);
        step();
        applyStimulus(2'b01, 3'b000, 5'b10100, 5'd8, 5'd4, 5'd6, 1'b1, 32'h20, 32'h21);
        checkOutput("lu_stall", 64'(stall_o), 64'd1);
        step();
        checkOutput("lu_bubble_valid", 64'(ex_valid), 64'd0);
        checkOutput("lu_bubble_m", 64'(ex_m), 64'd0);
        checkOutput("lu_cnt", 64'(bubble_cnt), 64'd1);
        checkOutput("lu_stall_drop", 64'(stall_o), 64'd0);
        step();
        checkOutput("lu_add_rs", 64'(ex_rs), 64'd8);

        // No false hazards: $zero target, and rt match without rt use
        applyStimulus(2'b11, 3'b010, 5'b00001, 5'd2, 5'd0, 5'd0, 1'b0, 32'h30, 32'h0);
        step();
        applyStimulus(2'b11, 3'b010, 5'b00001, 5'd0, 5'd9, 5'd0, 1'b0, 32'h31, 32'h0);
        checkOutput("zero_nohz", 64'(stall_o), 64'd0);
        step();
        applyStimulus(2'b01, 3'b000, 5'b10100, 5'd1, 5'd9, 5'd7, 1'b0, 32'h32, 32'h33);
        checkOutput("rt_unused_nohz", 64'(stall_o), 64'd0);
        applyStimulus(2'b01, 3'b000, 5'b10100, 5'd1, 5'd9, 5'd7, 1'b1, 32'h32, 32'h33);
        checkOutput("rt_used_hz", 64'(stall_o), 64'd1);

        // Flush beats hazard: bubble without counting
        flush_i = 1'b1;
        step();
        flush_i = 1'b0; #1;
        checkOutput("flush_valid", 64'(ex_valid), 64'd0);
        checkOutput("flush_cnt", 64'(bubble_cnt), 64'd1);
        step();

        // Stall hold with changing ID inputs
        stall_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            applyStimulus(2'b10, 3'b001, 5'b00011, 5'(i + 10), 5'(i + 12), 5'd1, 1'b1, 32'(i * 3 + 100), 32'(i));
            step();
        end
        checkOutput("stall_hold_rd1", 64'(ex_rd1), 64'h32);
        stall_i = 1'b0;
        step();
        checkOutput("stall_release_rd1", 64'(ex_rd1), 64'(32'd106));

        // Stall coincident with hazard: hold, no count, bubble afterwards
        applyStimulus(2'b11, 3'b010, 5'b00001, 5'd0, 5'd10, 5'd0, 1'b0, 32'h40, 32'h0);
        step();
        applyStimulus(2'b01, 3'b000, 5'b10100, 5'd10, 5'd3, 5'd4, 1'b1, 32'h41, 32'h42);
        stall_i = 1'b1;
        step();
        checkOutput("stallhz_valid", 64'(ex_valid), 64'd1);
        checkOutput("stallhz_cnt", 64'(bubble_cnt), 64'd1);
        stall_i = 1'b0;
        step();
        checkOutput("stallhz_bubble_cnt", 64'(bubble_cnt), 64'd2);
        step();

        // Saturation at 3 for CW=2
        for (int i = 0; i < 5; i++) begin
            applyStimulus(2'b11, 3'b010, 5'b00001, 5'd0, 5'd11, 5'd0, 1'b0, 32'(i + 80), 32'h0);
            step();
            applyStimulus(2'b01, 3'b000, 5'b10100, 5'd11, 5'd2, 5'd3, 1'b1, 32'(i + 90), 32'h1);
            step();
            step();
        end
        checkOutput("sat_cnt", 64'(bubble_cnt), 64'd3);

        // Reset in the middle of a hazard
        applyStimulus(2'b11, 3'b010, 5'b00001, 5'd0, 5'd12, 5'd0, 1'b0, 32'h50, 32'h0);
        step();
        applyStimulus(2'b01, 3'b000, 5'b10100, 5'd12, 5'd2, 5'd3, 1'b1, 32'h51, 32'h1);
        rst_n = 1'b0;
        step();
        checkOutput("midrst_stall", 64'(stall_o), 64'd0);
        checkOutput("midrst_cnt", 64'(bubble_cnt), 64'd0);
        rst_n = 1'b1;
        step();
        checkOutput("midrst_resume", 64'(ex_valid), 64'd1);
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
